// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(parameter int WIDTH = 4);
  logic load_valid;
  logic load_ready;
  logic [WIDTH-1:0] load_data;
  logic dout;
  logic dout_valid;
  logic bit_strobe;
  logic busy;
  logic done;
  modport master (
    output load_valid, load_data,
    input  load_ready, dout, dout_valid, bit_strobe, busy, done
  );
  modport slave (
    input  load_valid, load_data,
    output load_ready, dout, dout_valid, bit_strobe, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-to-serial transmitter; define PISO_PARITY_EN to append an even-parity bit
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input logic clk,
  input logic rst,
  piso_serializer_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DLAST = DW'(CLKS_PER_BIT - 1);
  if (WIDTH < 2 || CLKS_PER_BIT < 1) begin : g_bad_params
    $fatal(1, "piso_serializer: WIDTH must be >= 2 and CLKS_PER_BIT >= 1");
  end
`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] dcnt;
  assign bus.busy = (state != IDLE);
  assign bus.load_ready = (state == IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      bcnt <= '0;
      dcnt <= '0;
      bus.dout <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.bit_strobe <= 1'b0;
      bus.done <= 1'b0;
`ifdef PISO_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      bus.bit_strobe <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.dout <= 1'b0;
          bus.dout_valid <= 1'b0;
          if (bus.load_valid) begin
            state <= SHIFT;
            sr <= bus.load_data;
            bcnt <= '0;
            dcnt <= '0;
            bus.dout <= bus.load_data[WIDTH-1];
            bus.dout_valid <= 1'b1;
            bus.bit_strobe <= 1'b1;
`ifdef PISO_PARITY_EN
            par <= ^bus.load_data;
`endif
          end
        end
        SHIFT: begin
          if (dcnt == DLAST) begin
            sr <= sr << 1;
            bcnt <= bcnt + 1'b1;
            dcnt <= '0;
            if (bcnt == BLAST) begin
`ifdef PISO_PARITY_EN
              state <= PARITY;
              bus.dout <= par;
              bus.bit_strobe <= 1'b1;
`else
              state <= IDLE;
              bus.dout <= 1'b0;
              bus.dout_valid <= 1'b0;
              bus.done <= 1'b1;
`endif
            end else begin
              bus.dout <= sr[WIDTH-2];
              bus.bit_strobe <= 1'b1;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (dcnt == DLAST) begin
            state <= IDLE;
            dcnt <= '0;
            bus.dout <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table-driven and randomized checks of piso_serializer at CLKS_PER_BIT 1 and 3
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  piso_serializer_if #(.WIDTH(4)) i0 ();
  piso_serializer_if #(.WIDTH(4)) i1 ();
  piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(1)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(3)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  logic lv[2] = '{1'b0, 1'b0};
  logic [3:0] ld[2] = '{4'h0, 4'h0};
  logic [5:0] obs[2];
  assign i0.load_valid = lv[0];
  assign i0.load_data = ld[0];
  assign i1.load_valid = lv[1];
  assign i1.load_data = ld[1];
  assign obs[0] = {i0.dout, i0.dout_valid, i0.bit_strobe, i0.busy, i0.done, i0.load_ready};
  assign obs[1] = {i1.dout, i1.dout_valid, i1.bit_strobe, i1.busy, i1.done, i1.load_ready};
  int tests = 0;
  int fails = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask
  function automatic int cp(input int d);
    return d == 0 ? 1 : 3;
  endfunction
  // bit i of a frame: data MSB first, then even parity of the word
  function automatic logic mbit(input logic [3:0] w, input int i);
    return i < 4 ? w[3-i] : ^w;
  endfunction
  int cyc = 0;
  int e[2] = '{0, 0};
  int done_at[2] = '{-1, -1};
  logic act[2] = '{1'b0, 1'b0};
  logic [3:0] w[2] = '{4'h0, 4'h0};
  bit armed = 1'b0;
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rst) begin
        act[d] = 1'b0;
        done_at[d] = -1;
      end else if (lv[d] && !(act[d] && cyc - e[d] <= NB * cp(d))) begin
        act[d] = 1'b1;
        e[d] = cyc;
        w[d] = ld[d];
        done_at[d] = cyc + NB * cp(d) + 1;
      end
    if (rst) armed = 1'b1;
    cyc++;
  end
  always @(negedge clk) begin
    if (armed)
      for (int d = 0; d < 2; d++) begin
        automatic int k = cyc - e[d] - 1;
        automatic logic inf = act[d] && k >= 0 && k < NB * cp(d);
        automatic logic [5:0] x = {inf ? mbit(w[d], k / cp(d)) : 1'b0, inf,
                                   inf && (k % cp(d) == 0), inf, cyc == done_at[d], !inf};
        chk(d == 0 ? "model_cpb1" : "model_cpb3", {26'd0, obs[d]}, {26'd0, x});
      end
  end
  task automatic start(input int d, input logic [3:0] word);
    int n = 0;
    while (!obs[d][0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!obs[d][0]) chk("ready_timeout", {31'd0, obs[d][0]}, 1);
    lv[d] = 1'b1;
    ld[d] = word;
    @(posedge clk);
    #1;
    lv[d] = 1'b0;
    ld[d] = 4'($urandom);
  endtask
  task automatic run(input int d, input logic [3:0] word, input int pulse_at, input int rst_at,
                     output logic [4:0] cap, output int lat);
    cap = '0;
    lat = 0;
    start(d, word);
    for (int n = 1; n <= 40; n++) begin
      lv[d] = (n == pulse_at);
      if (n == pulse_at) ld[d] = 4'hF;
      rst = (n == rst_at);
      @(negedge clk);
      if (n == pulse_at) chk("busy_ready", {31'd0, obs[d][0]}, 0);
      if (rst_at > 0 && n == rst_at + 1) chk("reset_mid", {26'd0, obs[d]}, 32'b000001);
      if (obs[d][3]) cap = {cap[3:0], obs[d][5]};
      if (obs[d][1]) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    lv[d] = 1'b0;
    rst = 1'b0;
  endtask
  typedef struct {
    int d;
    logic [3:0] word;
    int pulse_at;
    int rst_at;
    logic [4:0] cap;
    int lat;
  } vec_t;
  vec_t tv[6];
  initial begin
    logic [4:0] cap;
    int lat;
`ifdef PISO_PARITY_EN
    tv[0] = '{0, 4'b1011, 0, 0, 5'b10111, 6};
    tv[1] = '{1, 4'b1001, 0, 0, 5'b10010, 16};
    tv[2] = '{0, 4'b0101, 2, 0, 5'b01010, 6};
    tv[3] = '{0, 4'b1010, 0, 2, 5'b00010, 0};
    tv[4] = '{0, 4'b0110, 0, 0, 5'b01100, 6};
    tv[5] = '{1, 4'b1111, 0, 0, 5'b11110, 16};
`else
    tv[0] = '{0, 4'b1011, 0, 0, 5'b01011, 5};
    tv[1] = '{1, 4'b1001, 0, 0, 5'b01001, 13};
    tv[2] = '{0, 4'b0101, 2, 0, 5'b00101, 5};
    tv[3] = '{0, 4'b1010, 0, 2, 5'b00010, 0};
    tv[4] = '{0, 4'b0110, 0, 0, 5'b00110, 5};
    tv[5] = '{1, 4'b1111, 0, 0, 5'b01111, 13};
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cpb1", {26'd0, obs[0]}, 32'b000001);
    chk("reset_cpb3", {26'd0, obs[1]}, 32'b000001);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run(tv[i].d, tv[i].word, tv[i].pulse_at, tv[i].rst_at, cap, lat);
      chk($sformatf("vec%0d_capture", i), {27'd0, cap}, {27'd0, tv[i].cap});
      chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
    end
    start(1, 4'b1001);
    for (int n = 1; n <= NB * 3 + 1; n++) begin
      @(negedge clk);
      chk("pace_strobe", {31'd0, obs[1][3]}, {31'd0, n <= NB * 3 && (n - 1) % 3 == 0});
      chk("pace_busy", {31'd0, obs[1][2]}, {31'd0, n <= NB * 3});
      chk("pace_done", {31'd0, obs[1][1]}, {31'd0, n == NB * 3 + 1});
    end
    lv[0] = 1'b1;
    ld[0] = 4'b1100;
    @(posedge clk);
    #1;
    ld[0] = 4'b0011;
    for (int n = 1; n <= 2 * NB + 1; n++) begin
      @(negedge clk);
      chk("b2b_valid", {31'd0, obs[0][4]}, {31'd0, n != NB + 1});
      chk("b2b_done", {31'd0, obs[0][1]}, {31'd0, n == NB + 1});
      chk("b2b_dout", {31'd0, obs[0][5]},
          {31'd0, n <= NB ? mbit(4'b1100, n - 1) : n == NB + 1 ? 1'b0 : mbit(4'b0011, n - NB - 2)});
      if (n == NB + 1) begin
        @(posedge clk);
        #1;
        lv[0] = 1'b0;
      end
    end
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++) begin
        lv[d] = ($urandom_range(0, 3) == 0);
        ld[d] = 4'($urandom);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    lv[0] = 1'b0;
    lv[1] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
